// File: rtl/thermal_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : thermal_ctrl_pkg
// Brief    : Shared types and constants for the multi-fan thermal controller.
// Revision : 1.0 - initial release
// ============================================================================
package thermal_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_CONVERT = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_TIMEOUT = 3'd4
    } ctrl_state_e;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_FULL   = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_RSVD   = 2'd3
    } fan_mode_e;

    // Raw ADC code 128 corresponds to 0 deg C.
    localparam logic [7:0] ADC_OFFSET   = 8'd128;
    localparam int         CLEAR_CYCLES = 4;

endpackage : thermal_ctrl_pkg
`default_nettype wire

// File: rtl/fan_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : fan_pwm_gen
// Brief    : Registered PWM comparator for one fan, phase-shifted on a shared
//            free-running counter.
// Revision : 1.0 - initial release
// ============================================================================
module fan_pwm_gen
    import thermal_ctrl_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PHASE    = 0
) (
    input  logic                clk50,
    input  logic                rstn,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                fan_on
);

    localparam logic [PWM_BITS-1:0] c_phase = PWM_BITS'(PHASE);

    logic [PWM_BITS-1:0] w_phased;
    logic                w_fan_on_d;
    logic                r_fan_on_q;

    // Inclusive compare: all-ones duty never drops, zero duty still gives one pulse.
    always_comb begin
        w_phased   = pwm_cnt + c_phase;
        w_fan_on_d = (w_phased <= duty);
    end

    always_ff @(posedge clk50) begin
        if (!rstn) begin
            r_fan_on_q <= 1'b1;
        end else begin
            r_fan_on_q <= w_fan_on_d;
        end
    end

    assign fan_on = r_fan_on_q;

endmodule : fan_pwm_gen
`default_nettype wire

// File: rtl/multi_fan_thermal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_fan_thermal_ctrl
// Brief    : Periodic temperature sampling, hysteretic fan-speed regulation,
//            alarm/watchdog overrides and staggered multi-fan PWM.
// Revision : 1.0 - initial release
// ============================================================================
module multi_fan_thermal_ctrl
    import thermal_ctrl_pkg::*;
#(
    parameter int NUM_FANS           = 2,
    parameter int PWM_BITS           = 8,
    parameter int SAMPLE_PERIOD_BITS = 20,
    parameter int TARGET_DEGC        = 40,
    parameter int HYST_DEGC          = 2,
    parameter int FAN_MIN            = ('h60 * (2 ** PWM_BITS)) / 256,
    parameter int ALARM_DEGC         = 85,
    parameter int TIMEOUT_BITS       = 16
) (
    input  logic                clk50,
    input  logic                rstn,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] manual_speed,
    output logic                sense_ce,
    output logic                sense_clr,
    input  logic                sense_done,
    input  logic [7:0]          sense_adc,
    output logic [7:0]          temperature_degc,
    output logic                sample_valid,
    output logic [PWM_BITS-1:0] fan_speed,
    output logic [NUM_FANS-1:0] fan_on,
    output logic                overtemp,
    output logic                sensor_fault
);

    localparam int                      c_clr_w     = $clog2(CLEAR_CYCLES);
    localparam logic [c_clr_w-1:0]      c_clr_last  = c_clr_w'(CLEAR_CYCLES - 1);
    localparam logic [TIMEOUT_BITS-1:0] c_to_max    = {TIMEOUT_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0]     c_fan_min   = PWM_BITS'(FAN_MIN);
    localparam logic signed [9:0]       c_up_thr    = 10'(TARGET_DEGC + HYST_DEGC);
    localparam logic signed [9:0]       c_dn_thr    = 10'(TARGET_DEGC - HYST_DEGC);
    localparam logic signed [9:0]       c_alarm     = 10'(ALARM_DEGC);
    localparam logic signed [9:0]       c_alarm_clr = 10'(ALARM_DEGC - HYST_DEGC);

    ctrl_state_e                   r_state_q,     w_state_d;
    logic [SAMPLE_PERIOD_BITS-1:0] r_samp_cnt_q,  w_samp_cnt_d;
    logic [c_clr_w-1:0]            r_clr_cnt_q,   w_clr_cnt_d;
    logic [TIMEOUT_BITS-1:0]       r_to_cnt_q,    w_to_cnt_d;
    logic [7:0]                    r_temp_q,      w_temp_d;
    logic                          r_sv_q,        w_sv_d;
    logic [PWM_BITS-1:0]           r_fan_speed_q, w_fan_speed_d;
    logic                          r_overtemp_q,  w_overtemp_d;
    logic                          r_fault_q,     w_fault_d;
    logic [PWM_BITS-1:0]           r_pwm_cnt_q,   w_pwm_cnt_d;

    logic [TIMEOUT_BITS-1:0]       w_to_cnt_inc;
    logic signed [9:0]             w_temp_ext;
    logic [PWM_BITS-1:0]           w_duty;

    always_ff @(posedge clk50) begin
        if (!rstn) begin
            r_state_q     <= ST_IDLE;
            r_samp_cnt_q  <= '0;
            r_clr_cnt_q   <= '0;
            r_to_cnt_q    <= '0;
            r_temp_q      <= 8'hFF;
            r_sv_q        <= 1'b0;
            r_fan_speed_q <= '1;
            r_overtemp_q  <= 1'b0;
            r_fault_q     <= 1'b0;
            r_pwm_cnt_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_samp_cnt_q  <= w_samp_cnt_d;
            r_clr_cnt_q   <= w_clr_cnt_d;
            r_to_cnt_q    <= w_to_cnt_d;
            r_temp_q      <= w_temp_d;
            r_sv_q        <= w_sv_d;
            r_fan_speed_q <= w_fan_speed_d;
            r_overtemp_q  <= w_overtemp_d;
            r_fault_q     <= w_fault_d;
            r_pwm_cnt_q   <= w_pwm_cnt_d;
        end
    end

    assign w_to_cnt_inc = r_to_cnt_q + 1'b1;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE:    if (r_samp_cnt_q == '0) w_state_d = ST_CLEAR;
            ST_CLEAR:   if (r_clr_cnt_q == c_clr_last) w_state_d = ST_CONVERT;
            ST_CONVERT: begin
                if (sense_done) begin
                    w_state_d = ST_UPDATE;
                end else if (w_to_cnt_inc == c_to_max) begin
                    w_state_d = ST_TIMEOUT;
                end
            end
            ST_UPDATE:  w_state_d = ST_IDLE;
            ST_TIMEOUT: w_state_d = ST_IDLE;
            default:    w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sense_ce  = 1'b0;
        sense_clr = 1'b0;
        case (r_state_q)
            ST_CLEAR: begin
                sense_ce  = 1'b1;
                sense_clr = 1'b1;
            end
            ST_CONVERT: sense_ce = 1'b1;
            default: ;
        endcase
    end

    assign w_temp_ext = {{2{r_temp_q[7]}}, r_temp_q};

    always_comb begin
        w_samp_cnt_d  = r_samp_cnt_q + 1'b1;
        w_pwm_cnt_d   = r_pwm_cnt_q + 1'b1;
        w_clr_cnt_d   = (r_state_q == ST_CLEAR) ? r_clr_cnt_q + 1'b1 : '0;
        w_to_cnt_d    = (r_state_q == ST_CONVERT) ? w_to_cnt_inc : '0;
        w_temp_d      = r_temp_q;
        w_sv_d        = 1'b0;
        w_fault_d     = r_fault_q;
        w_fan_speed_d = r_fan_speed_q;
        w_overtemp_d  = r_overtemp_q;

        if (r_state_q == ST_CONVERT) begin
            if (sense_done) begin
                w_temp_d  = sense_adc - ADC_OFFSET;
                w_sv_d    = 1'b1;
                w_fault_d = 1'b0;
            end else if (w_to_cnt_inc == c_to_max) begin
                w_fault_d = 1'b1;
            end
        end

        // Regulation runs regardless of mode so a return to auto is bumpless.
        if (r_state_q == ST_UPDATE) begin
            if (w_temp_ext > c_up_thr && r_fan_speed_q != '1) begin
                w_fan_speed_d = r_fan_speed_q + 1'b1;
            end else if (w_temp_ext < c_dn_thr && r_fan_speed_q > c_fan_min) begin
                w_fan_speed_d = r_fan_speed_q - 1'b1;
            end
            if (w_temp_ext >= c_alarm) begin
                w_overtemp_d = 1'b1;
            end else if (w_temp_ext < c_alarm_clr) begin
                w_overtemp_d = 1'b0;
            end
        end
    end

    always_comb begin
        w_duty = '1;
        if (!r_overtemp_q && !r_fault_q) begin
            case (fan_mode_e'(mode))
                MODE_AUTO:   w_duty = r_fan_speed_q;
                MODE_MANUAL: w_duty = manual_speed;
                default:     w_duty = '1;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_FANS; i++) begin : g_fan
        fan_pwm_gen #(
            .PWM_BITS (PWM_BITS),
            .PHASE    ((i * (2 ** PWM_BITS)) / NUM_FANS)
        ) u_pwm (
            .clk50   (clk50),
            .rstn    (rstn),
            .pwm_cnt (r_pwm_cnt_q),
            .duty    (w_duty),
            .fan_on  (fan_on[i])
        );
    end

    assign temperature_degc = r_temp_q;
    assign sample_valid     = r_sv_q;
    assign fan_speed        = r_fan_speed_q;
    assign overtemp         = r_overtemp_q;
    assign sensor_fault     = r_fault_q;

endmodule : multi_fan_thermal_ctrl
`default_nettype wire

// File: tb/tb_multi_fan_thermal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_fan_thermal_ctrl
// Brief    : Directed self-checking bench for multi_fan_thermal_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_fan_thermal_ctrl;

    logic       clk50        = 1'b0;
    logic       rstn         = 1'b0;
    logic [1:0] mode         = 2'd0;
    logic [7:0] manual_speed = 8'h00;
    logic       sense_done   = 1'b0;
    logic [7:0] sense_adc    = 8'h00;
    logic       sense_ce, sense_clr, sample_valid, overtemp, sensor_fault;
    logic [7:0] temperature_degc, fan_speed;
    logic [1:0] fan_on;

    int checks   = 0;
    int failures = 0;

    always #10 clk50 = ~clk50;

    multi_fan_thermal_ctrl #(
        .NUM_FANS           (2),
        .PWM_BITS           (8),
        .SAMPLE_PERIOD_BITS (8),
        .TIMEOUT_BITS       (6)
    ) dut (
        .clk50            (clk50),
        .rstn             (rstn),
        .mode             (mode),
        .manual_speed     (manual_speed),
        .sense_ce         (sense_ce),
        .sense_clr        (sense_clr),
        .sense_done       (sense_done),
        .sense_adc        (sense_adc),
        .temperature_degc (temperature_degc),
        .sample_valid     (sample_valid),
        .fan_speed        (fan_speed),
        .fan_on           (fan_on),
        .overtemp         (overtemp),
        .sensor_fault     (sensor_fault)
    );

    // Waits for a fresh CLEAR phase, then for the first CONVERT cycle.
    task automatic wait_convert(output bit ok);
        int n = 0;
        while (!(sense_ce && sense_clr) && n < 700) begin @(negedge clk50); n++; end
        while (!(sense_ce && !sense_clr) && n < 700) begin @(negedge clk50); n++; end
        ok = sense_ce && !sense_clr;
    endtask

    // Completes the current conversion and captures the results.
    task automatic finish_conv(input logic [7:0] adc, output logic [7:0] t, output logic sv,
                               output logic sv2, output logic [7:0] spd, output logic ot,
                               output logic flt);
        sense_adc = adc;
        @(negedge clk50);
        @(negedge clk50);
        sense_done = 1'b1;
        @(negedge clk50);
        sense_done = 1'b0;
        t  = temperature_degc;
        sv = sample_valid;
        @(negedge clk50);
        sv2 = sample_valid;
        spd = fan_speed;
        ot  = overtemp;
        flt = sensor_fault;
    endtask

    task automatic sample_window(input int n, output int h0, output int h1,
                                 output int r0, output int r1, output bit all_on);
        logic [1:0] prev;
        h0 = 0; h1 = 0; r0 = -1; r1 = -1; all_on = 1'b1;
        prev = fan_on;
        for (int i = 0; i < n; i++) begin
            @(negedge clk50);
            if (fan_on[0]) h0++;
            if (fan_on[1]) h1++;
            if (fan_on[0] && !prev[0] && r0 < 0) r0 = i;
            if (fan_on[1] && !prev[1] && r1 < 0) r1 = i;
            if (fan_on != 2'b11) all_on = 1'b0;
            prev = fan_on;
        end
    endtask

    task automatic test_reset;
        logic [7:0] t, spd;
        logic sv, sv2, ot, flt;
        int n;
        rstn = 1'b0;
        repeat (3) @(negedge clk50);
        checks++; if (temperature_degc !== 8'hFF) begin failures++; $display("FAIL rst_temp got=%h exp=ff", temperature_degc); end
        checks++; if (fan_speed !== 8'hFF) begin failures++; $display("FAIL rst_speed got=%h exp=ff", fan_speed); end
        checks++; if (fan_on !== 2'b11) begin failures++; $display("FAIL rst_fan_on got=%b exp=11", fan_on); end
        checks++; if ({sense_ce, sense_clr} !== 2'b00) begin failures++; $display("FAIL rst_sense got=%b exp=00", {sense_ce, sense_clr}); end
        checks++; if ({sample_valid, overtemp, sensor_fault} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {sample_valid, overtemp, sensor_fault}); end
        rstn = 1'b1;
        @(negedge clk50);
        checks++; if ({sense_ce, sense_clr} !== 2'b11) begin failures++; $display("FAIL start_after_rst got=%b exp=11", {sense_ce, sense_clr}); end
        n = 1;
        while (sense_clr && n < 10) begin
            @(negedge clk50);
            if (sense_clr) n++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL clear_len got=%0d exp=4", n); end
        checks++; if (sense_ce !== 1'b1) begin failures++; $display("FAIL convert_ce got=%b exp=1", sense_ce); end
        finish_conv(8'd178, t, sv, sv2, spd, ot, flt);
        checks++; if (t !== 8'd50) begin failures++; $display("FAIL temp50 got=%0d exp=50", t); end
        checks++; if (sv !== 1'b1) begin failures++; $display("FAIL sv_pulse got=%b exp=1", sv); end
        checks++; if (sv2 !== 1'b0) begin failures++; $display("FAIL sv_one_cycle got=%b exp=0", sv2); end
        checks++; if (spd !== 8'hFF) begin failures++; $display("FAIL speed_saturated got=%h exp=ff", spd); end
    endtask

    task automatic test_track_down;
        logic [7:0] t, spd, exp_spd;
        logic sv, sv2, ot, flt;
        bit ok;
        exp_spd = 8'hFF;
        for (int i = 0; i < 200; i++) begin
            wait_convert(ok);
            checks++; if (!ok) begin failures++; $display("FAIL down_wait sample=%0d got=timeout exp=convert", i); end
            finish_conv(8'd158, t, sv, sv2, spd, ot, flt);
            if (exp_spd > 8'h60) exp_spd = exp_spd - 8'd1;
            checks++; if (spd !== exp_spd) begin failures++; $display("FAIL down_speed sample=%0d got=%h exp=%h", i, spd, exp_spd); end
        end
        checks++; if (t !== 8'd30) begin failures++; $display("FAIL temp30 got=%0d exp=30", t); end
    endtask

    task automatic test_band;
        logic [7:0] t, spd;
        logic sv, sv2, ot, flt;
        bit ok, all_on;
        int h0, h1, r0, r1;
        logic [7:0] adc_v [8] = '{8'd169, 8'd170, 8'd171, 8'd213, 8'd211, 8'd210, 8'd166, 8'd165};
        logic [7:0] spd_v [8] = '{8'h60,  8'h60,  8'h61,  8'h62,  8'h63,  8'h64,  8'h64,  8'h63};
        logic       ot_v  [8] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b0};
        for (int i = 0; i < 8; i++) begin
            wait_convert(ok);
            checks++; if (!ok) begin failures++; $display("FAIL band_wait step=%0d got=timeout exp=convert", i); end
            finish_conv(adc_v[i], t, sv, sv2, spd, ot, flt);
            checks++; if (spd !== spd_v[i]) begin failures++; $display("FAIL band_speed adc=%0d got=%h exp=%h", adc_v[i], spd, spd_v[i]); end
            checks++; if (ot !== ot_v[i]) begin failures++; $display("FAIL band_overtemp adc=%0d got=%b exp=%b", adc_v[i], ot, ot_v[i]); end
            if (i == 3) begin
                sample_window(256, h0, h1, r0, r1, all_on);
                checks++; if (!all_on) begin failures++; $display("FAIL overtemp_full got=%0d/%0d exp=256/256", h0, h1); end
            end
            if (i == 5) begin
                sample_window(256, h0, h1, r0, r1, all_on);
                checks++; if (h0 !== 101 || h1 !== 101) begin failures++; $display("FAIL auto_duty got=%0d/%0d exp=101/101", h0, h1); end
            end
        end
        wait_convert(ok);
        finish_conv(8'd100, t, sv, sv2, spd, ot, flt);
        checks++; if (t !== 8'hE4) begin failures++; $display("FAIL neg_temp got=%h exp=e4", t); end
        checks++; if (spd !== 8'h62) begin failures++; $display("FAIL neg_speed got=%h exp=62", spd); end
    endtask

    task automatic test_fault;
        logic [7:0] t, spd;
        logic sv, sv2, ot, flt;
        bit ok, all_on;
        int n, h0, h1, r0, r1;
        wait_convert(ok);
        checks++; if (!ok) begin failures++; $display("FAIL fault_wait got=timeout exp=convert"); end
        n = 1;
        while (sense_ce && !sense_clr && n < 100) begin
            @(negedge clk50);
            if (sense_ce && !sense_clr) n++;
        end
        checks++; if (n !== 63) begin failures++; $display("FAIL convert_len got=%0d exp=63", n); end
        checks++; if ({sensor_fault, sense_ce} !== 2'b10) begin failures++; $display("FAIL fault_flag got=%b exp=10", {sensor_fault, sense_ce}); end
        checks++; if (temperature_degc !== 8'hE4) begin failures++; $display("FAIL fault_temp_hold got=%h exp=e4", temperature_degc); end
        sample_window(200, h0, h1, r0, r1, all_on);
        checks++; if (!all_on) begin failures++; $display("FAIL fault_full got=%0d/%0d exp=200/200", h0, h1); end
        wait_convert(ok);
        finish_conv(8'd169, t, sv, sv2, spd, ot, flt);
        checks++; if (flt !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", flt); end
        checks++; if (t !== 8'd41) begin failures++; $display("FAIL fault_recover_temp got=%0d exp=41", t); end
    endtask

    task automatic test_manual;
        logic [7:0] t, spd;
        logic sv, sv2, ot, flt;
        bit ok, all_on;
        int h0, h1, r0, r1;
        mode = 2'd2;
        manual_speed = 8'h7F;
        wait_convert(ok);
        finish_conv(8'd169, t, sv, sv2, spd, ot, flt);
        sample_window(256, h0, h1, r0, r1, all_on);
        checks++; if (h0 !== 128 || h1 !== 128) begin failures++; $display("FAIL manual_half got=%0d/%0d exp=128/128", h0, h1); end
        checks++; if (((r1 - r0 + 256) % 256) !== 128) begin failures++; $display("FAIL stagger got=%0d exp=128", (r1 - r0 + 256) % 256); end
        manual_speed = 8'h00;
        wait_convert(ok);
        finish_conv(8'd171, t, sv, sv2, spd, ot, flt);
        checks++; if (spd !== 8'h63) begin failures++; $display("FAIL bumpless_speed got=%h exp=63", spd); end
        sample_window(256, h0, h1, r0, r1, all_on);
        checks++; if (h0 !== 1 || h1 !== 1) begin failures++; $display("FAIL duty_zero got=%0d/%0d exp=1/1", h0, h1); end
    endtask

    task automatic test_mode_switch;
        logic [7:0] t, spd;
        logic sv, sv2, ot, flt;
        bit ok, all_on;
        int h0, h1, r0, r1;
        wait_convert(ok);
        finish_conv(8'd169, t, sv, sv2, spd, ot, flt);
        mode = 2'd1;
        @(negedge clk50);
        @(negedge clk50);
        checks++; if (fan_on !== 2'b11) begin failures++; $display("FAIL mode_full_latency got=%b exp=11", fan_on); end
        sample_window(64, h0, h1, r0, r1, all_on);
        checks++; if (!all_on) begin failures++; $display("FAIL mode_full got=%0d/%0d exp=64/64", h0, h1); end
        mode = 2'd2;
        sample_window(8, h0, h1, r0, r1, all_on);
        checks++; if (h0 + h1 > 2) begin failures++; $display("FAIL mode_manual_back got=%0d exp<=2", h0 + h1); end
        mode = 2'd3;
        @(negedge clk50);
        @(negedge clk50);
        sample_window(64, h0, h1, r0, r1, all_on);
        checks++; if (!all_on) begin failures++; $display("FAIL mode_rsvd got=%0d/%0d exp=64/64", h0, h1); end
        mode = 2'd0;
    endtask

    task automatic test_reset_mid_convert;
        logic [7:0] t, spd;
        logic sv, sv2, ot, flt;
        bit ok;
        wait_convert(ok);
        finish_conv(8'd213, t, sv, sv2, spd, ot, flt);
        checks++; if ({ot, spd} !== {1'b1, 8'h64}) begin failures++; $display("FAIL pre_reset got=%b/%h exp=1/64", ot, spd); end
        wait_convert(ok);
        repeat (5) @(negedge clk50);
        rstn = 1'b0;
        @(negedge clk50);
        checks++; if (temperature_degc !== 8'hFF || fan_speed !== 8'hFF) begin failures++; $display("FAIL mid_rst_regs got=%h/%h exp=ff/ff", temperature_degc, fan_speed); end
        checks++; if ({fan_on, sense_ce, sense_clr, sample_valid, overtemp, sensor_fault} !== 7'b1100000) begin
            failures++; $display("FAIL mid_rst_outs got=%b exp=1100000", {fan_on, sense_ce, sense_clr, sample_valid, overtemp, sensor_fault});
        end
        rstn = 1'b1;
        @(negedge clk50);
        checks++; if ({sense_ce, sense_clr} !== 2'b11) begin failures++; $display("FAIL mid_rst_restart got=%b exp=11", {sense_ce, sense_clr}); end
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_track_down;
        test_band;
        test_fault;
        test_manual;
        test_mode_switch;
        test_reset_mid_convert;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multi_fan_thermal_ctrl
`default_nettype wire

// File: doc/multi_fan_thermal_ctrl.md
MULTI_FAN_THERMAL_CTRL -- requirements
Module: multi_fan_thermal_ctrl

Interface
REQ-001 SHALL have parameter NUM_FANS, default 2, number of independent PWM fan outputs (1..8).
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and duty-cycle width.
REQ-003 SHALL have parameter SAMPLE_PERIOD_BITS, default 20, width of sample-interval counter.
REQ-004 SHALL have parameter TARGET_DEGC, default 40, signed 8-bit regulation setpoint.
REQ-005 SHALL have parameter HYST_DEGC, default 2, dead band either side of setpoint and alarm.
REQ-006 SHALL have parameter FAN_MIN, default 'h60 (scaled to PWM_BITS), minimum non-stall duty.
REQ-007 SHALL have parameter ALARM_DEGC, default 85, overtemperature threshold.
REQ-008 SHALL have parameter TIMEOUT_BITS, default 16, conversion watchdog width.
REQ-009 clk50  in  1  50 MHz clock, the only clock.
REQ-010 rstn  in  1  reset; synchronous, active-low.
REQ-011 mode  in  2  0=auto, 1=full, 2=manual, 3=reserved (treated as full).
REQ-012 manual_speed  in  PWM_BITS  duty used in manual mode.
REQ-013 sense_ce  out  1  sensor enable.
REQ-014 sense_clr  out  1  sensor clear.
REQ-015 sense_done  in  1  conversion complete.
REQ-016 sense_adc  in  8  raw ADC code.
REQ-017 temperature_degc  out  8  signed temperature, deg C.
REQ-018 sample_valid  out  1  one-cycle pulse when temperature_degc updates.
REQ-019 fan_speed  out  PWM_BITS  regulated duty (auto loop state).
REQ-020 fan_on  out  NUM_FANS  PWM fan drives.
REQ-021 overtemp  out  1  alarm flag.
REQ-022 sensor_fault  out  1  conversion-timeout flag.

Function
REQ-023 Sample counter SHALL free-run, wrapping at 2^SAMPLE_PERIOD_BITS; value 0 in IDLE SHALL start a sample.
REQ-024 FSM states IDLE -> CLEAR -> CONVERT -> UPDATE -> IDLE; TIMEOUT entered from CONVERT.
REQ-025 CLEAR SHALL last exactly 4 cycles with sense_ce=1, sense_clr=1.
REQ-026 CONVERT SHALL hold sense_ce=1, sense_clr=0 until sense_done; then temperature_degc <= sense_adc-128 (mod 256) and sample_valid pulses on that same edge.
REQ-027 CONVERT SHALL count cycles; reaching 2^TIMEOUT_BITS-1 without sense_done SHALL go to TIMEOUT, set sensor_fault, drop sense_ce, then return to IDLE; temperature_degc holds.
REQ-028 sensor_fault SHALL clear on the next successful conversion.
REQ-029 UPDATE (one cycle) SHALL: temp > TARGET+HYST and fan_speed < max -> +1; temp < TARGET-HYST and fan_speed > FAN_MIN -> -1; otherwise hold. All compares signed.
REQ-030 overtemp SHALL set in UPDATE when temp >= ALARM_DEGC and clear when temp < ALARM_DEGC-HYST_DEGC.
REQ-031 Effective duty SHALL be all-ones if overtemp or sensor_fault or mode in {1,3}; else manual_speed if mode=2; else fan_speed.
REQ-032 fan_speed SHALL keep regulating in every mode so auto resumption is bumpless.
REQ-033 PWM counter SHALL free-run over PWM_BITS; fan n SHALL compare (cnt + n*2^PWM_BITS/NUM_FANS) mod 2^PWM_BITS <= duty, staggering edges.
REQ-034 fan_on SHALL be registered; duty all-ones SHALL give constant 1; duty 0 SHALL give 1-in-2^PWM_BITS pulses.
REQ-035 mode changes SHALL take effect on fan_on within 2 cycles.

Reset
REQ-036 rstn=0 at a clock edge SHALL set: temperature_degc='hFF, fan_speed all-ones, fan_on all-ones, sense_ce=0, sense_clr=0, sample_valid=0, overtemp=0, sensor_fault=0, FSM IDLE, all counters 0.
REQ-037 Reset mid-CONVERT SHALL abort the conversion; a sample SHALL begin on the first cycle after release.

Structure
REQ-038 Package thermal_ctrl_pkg SHALL hold the FSM state enum, mode enum, ADC offset 128 and CLEAR_CYCLES=4.
REQ-039 Sub-module fan_pwm_gen (parameters PWM_BITS, PHASE) SHALL be instantiated once per fan.

Verification (SAMPLE_PERIOD_BITS=8, TIMEOUT_BITS=6)
REQ-040 sense_adc=178 (50 C), auto, from reset -> sample_valid, temperature_degc=50, fan_speed stays 'hFF (saturated).
REQ-041 sense_adc=158 (30 C), 200 samples -> fan_speed decrements once per sample, floors at 'h60.
REQ-042 sense_adc=169 (41 C, within band) -> fan_speed unchanged; sense_adc=213 (85 C) -> overtemp=1, fan_on constant 1; sense_adc=210 (82 C) -> overtemp=0.
REQ-043 sense_done held 0 -> sensor_fault=1 after 63 CONVERT cycles, fan_on constant 1; next good sample clears it.
REQ-044 NUM_FANS=2, mode=2, manual_speed='h7F -> each fan 50% duty, edges 128 cycles apart; rstn low mid-CONVERT -> all REQ-036 values next edge.
